// File: rtl/obstacle_scroller.sv
// Obstacle field generator: two mountains and a lava blob scrolled left once per
// frame_tick while running, respawning at the right edge with LFSR-derived heights.
module obstacle_scroller #(
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter int          SPEED        = 1,
  parameter int          LAVA_DROP    = 2,
  parameter int          MTN_Y_BASE   = 40,
  parameter int          M1_START_X   = 159,
  parameter int          M2_START_X   = 80,
  parameter int          LAVA_START_X = 120,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       game_over,
  output logic [9:0] mountain1_x_pos,
  output logic [9:0] mountain1_y_pos,
  output logic [9:0] mountain2_x_pos,
  output logic [9:0] mountain2_y_pos,
  output logic [9:0] lava_x_pos,
  output logic [9:0] lava_y_pos,
  output logic [7:0] score,
  output logic       running,
  output logic       update_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  localparam logic signed [10:0] SPEED_S   = 11'(SPEED);
  localparam logic [9:0]         RESPAWN_X = 10'(SCREEN_W - 1);
  localparam logic [10:0]        LAVA_MAX  = 11'(SCREEN_H - 1);
  localparam logic [10:0]        DROP_W    = 11'(LAVA_DROP);
  localparam logic [10:0]        Y_BASE_W  = 11'(MTN_Y_BASE);
  localparam logic [9:0]         Y_BASE    = 10'(MTN_Y_BASE);
  localparam logic [9:0]         M1_X0     = 10'(M1_START_X);
  localparam logic [9:0]         M2_X0     = 10'(M2_START_X);
  localparam logic [9:0]         LAVA_X0   = 10'(LAVA_START_X);

  state_t state, state_next;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic       do_update, do_reload;

  logic signed [10:0] m1_diff, m2_diff, lava_diff;
  logic               m1_wrap, m2_wrap, lava_wrap;
  logic [10:0]        m1_y_resp, m2_y_resp, lava_y_sum;
  logic [9:0]         m1_x_step, m1_y_step, m2_x_step, m2_y_step;
  logic [9:0]         lava_x_step, lava_y_step;
  logic [7:0]         score_step;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_next = state;
    do_update  = 1'b0;
    do_reload  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = RUN;
        do_reload  = 1'b1;
      end
      RUN: begin
        // A crash in the same cycle as a frame tick suppresses the update.
        if (game_over)       state_next = FREEZE;
        else if (frame_tick) do_update  = 1'b1;
      end
      FREEZE: if (start) begin
        state_next = RUN;
        do_reload  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m1_diff   = $signed({1'b0, mountain1_x_pos}) - SPEED_S;
    m2_diff   = $signed({1'b0, mountain2_x_pos}) - SPEED_S;
    lava_diff = $signed({1'b0, lava_x_pos}) - SPEED_S;
    m1_wrap   = (m1_diff < 0);
    m2_wrap   = (m2_diff < 0);
    lava_wrap = (lava_diff < 0);

    m1_y_resp  = Y_BASE_W + {6'b0, lfsr[4:0]};
    m2_y_resp  = Y_BASE_W + {6'b0, lfsr[7:3]};
    lava_y_sum = {1'b0, lava_y_pos} + DROP_W;

    m1_x_step = m1_wrap ? RESPAWN_X : m1_diff[9:0];
    m1_y_step = m1_wrap ? m1_y_resp[9:0] : mountain1_y_pos;
    m2_x_step = m2_wrap ? RESPAWN_X : m2_diff[9:0];
    m2_y_step = m2_wrap ? m2_y_resp[9:0] : mountain2_y_pos;

    lava_x_step = lava_wrap ? RESPAWN_X : lava_diff[9:0];
    if (lava_wrap || (lava_y_sum > LAVA_MAX)) lava_y_step = 10'd0;
    else                                      lava_y_step = lava_y_sum[9:0];

    score_step = sat_add(score, count2(m1_wrap, m2_wrap));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      lfsr            <= LFSR_SEED;
      running         <= 1'b0;
      update_pulse    <= 1'b0;
      mountain1_x_pos <= M1_X0;
      mountain1_y_pos <= Y_BASE;
      mountain2_x_pos <= M2_X0;
      mountain2_y_pos <= Y_BASE;
      lava_x_pos      <= LAVA_X0;
      lava_y_pos      <= 10'd0;
      score           <= 8'd0;
    end else begin
      state        <= state_next;
      lfsr         <= {lfsr[6:0], lfsr_fb};
      running      <= (state_next == RUN);
      update_pulse <= do_update;
      if (do_reload) begin
        mountain1_x_pos <= M1_X0;
        mountain1_y_pos <= Y_BASE;
        mountain2_x_pos <= M2_X0;
        mountain2_y_pos <= Y_BASE;
        lava_x_pos      <= LAVA_X0;
        lava_y_pos      <= 10'd0;
        score           <= 8'd0;
      end else if (do_update) begin
        mountain1_x_pos <= m1_x_step;
        mountain1_y_pos <= m1_y_step;
        mountain2_x_pos <= m2_x_step;
        mountain2_y_pos <= m2_y_step;
        lava_x_pos      <= lava_x_step;
        lava_y_pos      <= lava_y_step;
        score           <= score_step;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: scrolling, respawn, lava wrap, freeze,
// restart, score saturation and asynchronous reset.
module tb_obstacle_scroller;

  logic       clk = 1'b0;
  logic       reset, start, frame_tick, game_over;
  logic [9:0] m1_x, m1_y, m2_x, m2_y, lava_x, lava_y;
  logic [7:0] score;
  logic       running, update_pulse;

  int passed = 0;
  int total  = 0;
  logic pulse_seen;

  obstacle_scroller dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .game_over(game_over),
    .mountain1_x_pos(m1_x), .mountain1_y_pos(m1_y),
    .mountain2_x_pos(m2_x), .mountain2_y_pos(m2_y),
    .lava_x_pos(lava_x), .lava_y_pos(lava_y),
    .score(score), .running(running), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Each tick is a one-cycle frame_tick pulse; update_pulse is sampled after every edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      if (update_pulse) pulse_seen = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      if (update_pulse) pulse_seen = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    pulse_seen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_m1_x", m1_x, 159);
    check("rst_m2_x", m2_x, 80);
    check("rst_lava_x", lava_x, 120);
    check("rst_m1_y", m1_y, 40);
    check("rst_lava_y", lava_y, 0);
    check("rst_score", score, 0);
    check("rst_running", running, 0);
    check("rst_pulse", update_pulse, 0);

    tick_n(5);
    check("idle_m1_x", m1_x, 159);
    check("idle_m2_x", m2_x, 80);
    check("idle_lava_x", lava_x, 120);
    check("idle_running", running, 0);
    check("idle_no_pulse", pulse_seen, 0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_running", running, 1);
    check("start_pulse_low", update_pulse, 0);

    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("t1_pulse_high", update_pulse, 1);
    check("t1_m1_x", m1_x, 158);
    check("t1_m2_x", m2_x, 79);
    check("t1_lava_x", lava_x, 119);
    check("t1_lava_y", lava_y, 2);
    @(negedge clk);
    check("t1_pulse_low", update_pulse, 0);

    tick_n(58);
    check("t59_lava_y", lava_y, 118);
    tick_n(1);
    check("t60_lava_y_wrap", lava_y, 0);
    check("t60_lava_x", lava_x, 60);
    check("t60_score", score, 0);

    tick_n(21);
    check("t81_m2_x", m2_x, 159);
    check("t81_m2_y_range", (m2_y >= 40 && m2_y <= 71), 1);
    check("t81_score", score, 1);
    check("t81_m1_x", m1_x, 78);
    check("t81_lava_x", lava_x, 39);
    check("t81_lava_y", lava_y, 42);

    @(negedge clk); game_over = 1'b1; frame_tick = 1'b1;
    @(negedge clk); game_over = 1'b0; frame_tick = 1'b0;
    check("go_m1_x", m1_x, 78);
    check("go_m2_x", m2_x, 159);
    check("go_lava_x", lava_x, 39);
    check("go_running", running, 0);
    check("go_pulse", update_pulse, 0);

    pulse_seen = 1'b0;
    tick_n(3);
    check("frz_m1_x", m1_x, 78);
    check("frz_no_pulse", pulse_seen, 0);
    check("frz_score", score, 1);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rs_m1_x", m1_x, 159);
    check("rs_m2_x", m2_x, 80);
    check("rs_lava_x", lava_x, 120);
    check("rs_m2_y", m2_y, 40);
    check("rs_lava_y", lava_y, 0);
    check("rs_score", score, 0);
    check("rs_running", running, 1);

    // Continuous frame_tick: 125+125 respawns by tick 20000, 262 by 21000.
    @(negedge clk); frame_tick = 1'b1;
    repeat (20000) @(negedge clk);
    check("sat_score_250", score, 250);
    repeat (1000) @(negedge clk);
    frame_tick = 1'b0;
    check("sat_score_255", score, 255);
    check("sat_m1_x", m1_x, 119);

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_m1_x", m1_x, 159);
    check("arst_m2_x", m2_x, 80);
    check("arst_lava_x", lava_x, 120);
    check("arst_score", score, 0);
    check("arst_running", running, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post_arst_running", running, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
